// File: rtl/dvp_pkg.sv
// Shared constants and channel-expansion helpers for the DVP capture path.
// GS_OUT_W widens to a packed 32-bit word when DVP_GS_PACK_EN is defined.
package dvp_pkg;

    localparam int RGB_PXL_W = 16;
    localparam int GS_PXL_W  = 8;

    localparam int GS_WR  = 77;
    localparam int GS_WG  = 150;
    localparam int GS_WB  = 29;
    localparam int GS_RND = 128;

    localparam int GS_PACK_N = 4;

`ifdef DVP_GS_PACK_EN
    localparam int GS_OUT_W = GS_PACK_N * GS_PXL_W;
`else
    localparam int GS_OUT_W = GS_PXL_W;
`endif

    // Bit replication keeps full-scale inputs at exactly 8'hFF.
    function automatic logic [GS_PXL_W-1:0] expand5(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

    function automatic logic [GS_PXL_W-1:0] expand6(input logic [5:0] c);
        return {c, c[5:4]};
    endfunction

endpackage

// File: rtl/dvp_gs_pack.sv
// Packs four consecutive gray pixels little-endian into one 32-bit word.
// Only instantiated by dvp_gray_scale when DVP_GS_PACK_EN is defined.
module dvp_gs_pack
    import dvp_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [GS_PXL_W-1:0]             pxl_i,
    input  logic                            pxl_vld_i,
    output logic                            pxl_rdy_o,
    output logic [GS_PACK_N*GS_PXL_W-1:0]   word_o,
    output logic                            word_vld_o,
    input  logic                            word_rdy_i
);

    localparam int LANE_W = $clog2(GS_PACK_N);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(GS_PACK_N - 1);

    logic [GS_PACK_N*GS_PXL_W-1:0] word_q, word_d;
    logic [LANE_W-1:0]             lane_q, lane_d;
    logic                          full_q, full_d;
    logic                          in_xfer;
    logic                          out_xfer;

    // A full word can be replaced in the same cycle it is taken.
    assign pxl_rdy_o = ~full_q | word_rdy_i;
    assign in_xfer   = pxl_vld_i & pxl_rdy_o;
    assign out_xfer  = full_q & word_rdy_i;

    always_comb begin
        word_d = word_q;
        lane_d = lane_q;
        full_d = full_q;
        if (out_xfer) begin
            full_d = 1'b0;
        end
        if (in_xfer) begin
            word_d[lane_q*GS_PXL_W +: GS_PXL_W] = pxl_i;
            lane_d = lane_q + LANE_W'(1);
            if (lane_q == LANE_LAST) begin
                full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            lane_q <= '0;
            full_q <= 1'b0;
        end else begin
            word_q <= word_d;
            lane_q <= lane_d;
            full_q <= full_d;
        end
    end

    assign word_o     = word_q;
    assign word_vld_o = full_q;

endmodule

// File: rtl/dvp_gray_scale.sv
// Two-stage RGB565 -> 8-bit luma converter with valid/ready on both sides.
// DVP_GS_PACK_EN adds a packer emitting four gray pixels per 32-bit word.
module dvp_gray_scale
    import dvp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [RGB_PXL_W-1:0] rgb_pxl_i,
    input  logic                 rgb_pxl_vld_i,
    output logic                 rgb_pxl_rdy_o,
    output logic [GS_OUT_W-1:0]  gs_pxl_o,
    output logic                 gs_pxl_vld_o,
    input  logic                 gs_pxl_rdy_i
);

    logic [GS_PXL_W-1:0] r8, g8, b8;
    logic [15:0]         pr_q, pg_q, pb_q;
    logic [15:0]         pr_d, pg_d, pb_d;
    logic                s1_vld_q;
    logic [GS_PXL_W-1:0] y_q, y_d;
    logic                s2_vld_q;
    logic                s1_en, s2_en;
    logic                s2_rdy;

    assign r8 = expand5(rgb_pxl_i[15:11]);
    assign g8 = expand6(rgb_pxl_i[10:5]);
    assign b8 = expand5(rgb_pxl_i[4:0]);

    assign pr_d = 16'(GS_WR) * {8'd0, r8};
    assign pg_d = 16'(GS_WG) * {8'd0, g8};
    assign pb_d = 16'(GS_WB) * {8'd0, b8};

    // Weights sum to 256, so the rounded 16-bit sum cannot overflow.
    assign y_d = 8'((pr_q + pg_q + pb_q + 16'(GS_RND)) >> 8);

    // Downstream ready reaches rgb_pxl_rdy_o through AND/OR only.
    assign s2_en         = ~s2_vld_q | s2_rdy;
    assign s1_en         = ~s1_vld_q | s2_en;
    assign rgb_pxl_rdy_o = s1_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pr_q     <= '0;
            pg_q     <= '0;
            pb_q     <= '0;
            s1_vld_q <= 1'b0;
            y_q      <= '0;
            s2_vld_q <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_vld_q <= rgb_pxl_vld_i;
                if (rgb_pxl_vld_i) begin
                    pr_q <= pr_d;
                    pg_q <= pg_d;
                    pb_q <= pb_d;
                end
            end
            if (s2_en) begin
                s2_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    y_q <= y_d;
                end
            end
        end
    end

`ifdef DVP_GS_PACK_EN
    dvp_gs_pack u_pack (
        .clk        (clk),
        .rst_n      (rst_n),
        .pxl_i      (y_q),
        .pxl_vld_i  (s2_vld_q),
        .pxl_rdy_o  (s2_rdy),
        .word_o     (gs_pxl_o),
        .word_vld_o (gs_pxl_vld_o),
        .word_rdy_i (gs_pxl_rdy_i)
    );
`else
    assign s2_rdy       = gs_pxl_rdy_i;
    assign gs_pxl_o     = y_q;
    assign gs_pxl_vld_o = s2_vld_q;
`endif

endmodule

// File: tb/tb_dvp_gray_scale.sv
// Directed/self-checking bench for dvp_gray_scale (default and DVP_GS_PACK_EN builds).
module tb_dvp_gray_scale;
    import dvp_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [RGB_PXL_W-1:0] rgb_pxl_i;
    logic                 rgb_pxl_vld_i;
    logic                 rgb_pxl_rdy_o;
    logic [GS_OUT_W-1:0]  gs_pxl_o;
    logic                 gs_pxl_vld_o;
    logic                 gs_pxl_rdy_i;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [15:0] tab[1000];

    always #5 clk = ~clk;

    dvp_gray_scale dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rgb_pxl_i     (rgb_pxl_i),
        .rgb_pxl_vld_i (rgb_pxl_vld_i),
        .rgb_pxl_rdy_o (rgb_pxl_rdy_o),
        .gs_pxl_o      (gs_pxl_o),
        .gs_pxl_vld_o  (gs_pxl_vld_o),
        .gs_pxl_rdy_i  (gs_pxl_rdy_i)
    );

    function automatic logic [7:0] ref_luma(input logic [15:0] p);
        int r, g, b, y;
        r = int'({p[15:11], p[15:13]});
        g = int'({p[10:5], p[10:9]});
        b = int'({p[4:0], p[4:2]});
        y = (77 * r + 150 * g + 29 * b + 128) / 256;
        return y[7:0];
    endfunction

    // Records the transfers about to happen at the next edge, then steps past it.
    task automatic tick();
        @(negedge clk);
        if (rgb_pxl_vld_i && rgb_pxl_rdy_o) exp_q.push_back(ref_luma(rgb_pxl_i));
        if (gs_pxl_vld_o && gs_pxl_rdy_i) got_q.push_back(gs_pxl_o[7:0]);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        rgb_pxl_i     = '0;
        rgb_pxl_vld_i = 1'b0;
        gs_pxl_rdy_i  = 1'b1;
        #12;
        n_vec++;
        if (gs_pxl_vld_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_vld: got %b want 0", gs_pxl_vld_o);
        end
        n_vec++;
        if (gs_pxl_o !== '0) begin
            n_err++;
            $display("FAIL reset_data: got %h want 0", gs_pxl_o);
        end
        n_vec++;
        if (rgb_pxl_rdy_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_rdy: got %b want 1", rgb_pxl_rdy_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

`ifndef DVP_GS_PACK_EN
    task automatic test_single();
        logic [15:0] vin[5];
        logic [7:0]  vout[5];
        vin  = '{16'hFFFF, 16'h0000, 16'hF800, 16'h07E0, 16'h001F};
        vout = '{8'hFF, 8'h00, 8'h4D, 8'h95, 8'h1D};
        gs_pxl_rdy_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rgb_pxl_i     = vin[i];
            rgb_pxl_vld_i = 1'b1;
            #1;
            n_vec++;
            if (rgb_pxl_rdy_o !== 1'b1) begin
                n_err++;
                $display("FAIL single_rdy[%0d]: got %b want 1", i, rgb_pxl_rdy_o);
            end
            @(posedge clk);
            #1;
            rgb_pxl_vld_i = 1'b0;
            n_vec++;
            if (gs_pxl_vld_o !== 1'b0) begin
                n_err++;
                $display("FAIL single_early[%0d]: vld got %b want 0", i, gs_pxl_vld_o);
            end
            @(posedge clk);
            #1;
            n_vec++;
            if (gs_pxl_vld_o !== 1'b1 || gs_pxl_o !== vout[i]) begin
                n_err++;
                $display("FAIL single_out[%0d]: got vld=%b data=%h want vld=1 data=%h",
                         i, gs_pxl_vld_o, gs_pxl_o, vout[i]);
            end
            @(posedge clk);
            #1;
            n_vec++;
            if (gs_pxl_vld_o !== 1'b0) begin
                n_err++;
                $display("FAIL single_dup[%0d]: vld got %b want 0", i, gs_pxl_vld_o);
            end
        end
    endtask

    task automatic compare_streams(input string name, input int n);
        int shown = 0;
        n_vec++;
        if (got_q.size() != n || exp_q.size() != n) begin
            n_err++;
            $display("FAIL %s_count: got %0d outputs / %0d inputs want %0d", name,
                     got_q.size(), exp_q.size(), n);
        end
        for (int i = 0; i < n && i < got_q.size() && i < exp_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                if (shown < 5) $display("FAIL %s_data[%0d]: got %h want %h", name, i, got_q[i], exp_q[i]);
                shown++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int bubbles = 0;
        int not_rdy = 0;
        exp_q.delete();
        got_q.delete();
        gs_pxl_rdy_i = 1'b1;
        for (int i = 0; i < 64; i++) begin
            rgb_pxl_i     = 16'($urandom);
            rgb_pxl_vld_i = 1'b1;
            #1;
            if (rgb_pxl_rdy_o !== 1'b1) not_rdy++;
            tick();
            if (i >= 1 && gs_pxl_vld_o !== 1'b1) bubbles++;
        end
        rgb_pxl_vld_i = 1'b0;
        for (int c = 0; c < 10 && got_q.size() < 64; c++) tick();
        n_vec++;
        if (not_rdy != 0) begin
            n_err++;
            $display("FAIL b2b_rdy: got %0d stalled cycles want 0", not_rdy);
        end
        n_vec++;
        if (bubbles != 0) begin
            n_err++;
            $display("FAIL b2b_bubble: got %0d bubbles want 0", bubbles);
        end
        compare_streams("b2b", 64);
    endtask

    task automatic test_stall();
        logic [7:0] held;
        bit         have = 0;
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < 8; i++) tab[i] = 16'($urandom);
        gs_pxl_rdy_i  = 1'b0;
        rgb_pxl_vld_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            rgb_pxl_i = tab[exp_q.size()];
            tick();
            if (gs_pxl_vld_o === 1'b1) begin
                if (!have) begin
                    held = gs_pxl_o[7:0];
                    have = 1;
                end else begin
                    n_vec++;
                    if (gs_pxl_o[7:0] !== held) begin
                        n_err++;
                        $display("FAIL stall_hold[%0d]: got %h want %h", c, gs_pxl_o, held);
                    end
                end
            end
        end
        n_vec++;
        if (exp_q.size() != 2) begin
            n_err++;
            $display("FAIL stall_accepted: got %0d want 2", exp_q.size());
        end
        n_vec++;
        if (rgb_pxl_rdy_o !== 1'b0) begin
            n_err++;
            $display("FAIL stall_rdy: got %b want 0", rgb_pxl_rdy_o);
        end
        gs_pxl_rdy_i = 1'b1;
        for (int c = 0; c < 40 && exp_q.size() < 8; c++) begin
            rgb_pxl_i = tab[exp_q.size()];
            tick();
        end
        rgb_pxl_vld_i = 1'b0;
        for (int c = 0; c < 10 && got_q.size() < 8; c++) tick();
        compare_streams("stall", 8);
    endtask

    task automatic test_random();
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < 1000; i++) tab[i] = 16'($urandom);
        for (int c = 0; c < 20000 && got_q.size() < 1000; c++) begin
            if (exp_q.size() < 1000) begin
                rgb_pxl_i     = tab[exp_q.size()];
                rgb_pxl_vld_i = 1'($urandom_range(0, 1));
            end else begin
                rgb_pxl_vld_i = 1'b0;
            end
            gs_pxl_rdy_i = 1'($urandom_range(0, 1));
            tick();
        end
        rgb_pxl_vld_i = 1'b0;
        gs_pxl_rdy_i  = 1'b1;
        compare_streams("random", 1000);
    endtask

    task automatic test_reset_mid();
        exp_q.delete();
        got_q.delete();
        gs_pxl_rdy_i  = 1'b0;
        rgb_pxl_vld_i = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() < 2; c++) begin
            rgb_pxl_i = (exp_q.size() == 0) ? 16'hFFFF : 16'hF800;
            tick();
        end
        rgb_pxl_vld_i = 1'b0;
        @(negedge clk);
        n_vec++;
        if (gs_pxl_vld_o !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_pre: vld got %b want 1", gs_pxl_vld_o);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (gs_pxl_vld_o !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_vld: got %b want 0", gs_pxl_vld_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        got_q.delete();
        gs_pxl_rdy_i  = 1'b1;
        rgb_pxl_i     = 16'h07E0;
        rgb_pxl_vld_i = 1'b1;
        tick();
        rgb_pxl_vld_i = 1'b0;
        for (int c = 0; c < 10 && got_q.size() < 1; c++) tick();
        n_vec++;
        if (got_q.size() < 1) begin
            n_err++;
            $display("FAIL rstmid_first: got no output want 95");
        end else if (got_q[0] !== 8'h95) begin
            n_err++;
            $display("FAIL rstmid_first: got %h want 95", got_q[0]);
        end
    endtask
`else
    task automatic test_pack();
        logic [15:0] w0[4];
        logic [15:0] w1[4];
        logic [31:0] seen;
        bit          ok = 0;
        w0 = '{16'hFFFF, 16'h0000, 16'hF800, 16'h001F};
        w1 = '{16'h001F, 16'hF800, 16'h0000, 16'hFFFF};
        gs_pxl_rdy_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rgb_pxl_i     = w0[k];
            rgb_pxl_vld_i = 1'b1;
            @(posedge clk);
            #1;
        end
        rgb_pxl_vld_i = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (gs_pxl_vld_o !== 1'b0) begin
            n_err++;
            $display("FAIL pack_early: vld got %b want 0", gs_pxl_vld_o);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (gs_pxl_vld_o !== 1'b1 || gs_pxl_o !== 32'h1D4D00FF) begin
            n_err++;
            $display("FAIL pack_word0: got vld=%b data=%h want vld=1 data=1d4d00ff", gs_pxl_vld_o, gs_pxl_o);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (gs_pxl_vld_o !== 1'b1 || gs_pxl_o !== 32'h1D4D00FF) begin
                n_err++;
                $display("FAIL pack_hold[%0d]: got vld=%b data=%h want 1d4d00ff", c, gs_pxl_vld_o, gs_pxl_o);
            end
        end
        gs_pxl_rdy_i = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (gs_pxl_vld_o !== 1'b0) begin
            n_err++;
            $display("FAIL pack_taken: vld got %b want 0", gs_pxl_vld_o);
        end
        gs_pxl_rdy_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rgb_pxl_i     = w1[k];
            rgb_pxl_vld_i = 1'b1;
            @(posedge clk);
            #1;
        end
        rgb_pxl_vld_i = 1'b0;
        for (int c = 0; c < 10 && !ok; c++) begin
            @(posedge clk);
            #1;
            if (gs_pxl_vld_o === 1'b1) begin
                ok   = 1;
                seen = gs_pxl_o;
            end
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL pack_word1: no word want ff004d1d");
        end else if (seen !== 32'hFF004D1D) begin
            n_err++;
            $display("FAIL pack_word1: got %h want ff004d1d", seen);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifndef DVP_GS_PACK_EN
        test_single();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_mid();
`else
        test_pack();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
